// File: rtl/ps2_note_voices.sv
// Polyphonic PS/2 note decoder: decodes make/F0/E0 sequences into up to VOICES held-key slots with frequency words.
// Latency: byte consumed at edge T, outputs updated at edge T+1; reads at most one byte per 2 cycles via nextdata_n.
module ps2_note_voices #(
    parameter int VOICES = 4,
    parameter int FREQ_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic [7:0]               k_data,
    input  logic                     ready,
    input  logic                     overflow,
    input  logic                     panic,
    output logic                     nextdata_n,
    output logic [VOICES-1:0]        voice_on,
    output logic [VOICES*FREQ_W-1:0] voice_freq,
    output logic [7:0]               last_code,
    output logic [CNT_W-1:0]         keycount,
    output logic                     drop,
    output logic                     err
);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    function automatic logic [FREQ_W-1:0] note_freq(input logic [7:0] c);
        case (c)
            8'h1C:   note_freq = FREQ_W'(16'h0106);
            8'h1B:   note_freq = FREQ_W'(16'h0115);
            8'h23:   note_freq = FREQ_W'(16'h0126);
            8'h2B:   note_freq = FREQ_W'(16'h0137);
            8'h34:   note_freq = FREQ_W'(16'h014A);
            8'h33:   note_freq = FREQ_W'(16'h015D);
            8'h3B:   note_freq = FREQ_W'(16'h0172);
            8'h42:   note_freq = FREQ_W'(16'h0188);
            8'h4B:   note_freq = FREQ_W'(16'h019F);
            8'h4C:   note_freq = FREQ_W'(16'h01B8);
            8'h52:   note_freq = FREQ_W'(16'h01D2);
            8'h5A:   note_freq = FREQ_W'(16'h01EE);
            default: note_freq = '0;
        endcase
    endfunction

    state_t                     state_q, state_d;
    logic                       rd_n_q;
    logic                       byte_vld_q;
    logic [7:0]                 byte_q;
    logic [VOICES-1:0]          on_q, on_d;
    logic [7:0]                 code_q [VOICES];
    logic [7:0]                 code_d [VOICES];
    logic [VOICES*FREQ_W-1:0]   freq_q, freq_d;
    logic [7:0]                 last_q, last_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       drop_q, drop_d;
    logic                       err_q;

    logic                       consume;
    logic                       is_make, is_break, held, free_found;
    logic [VOICES-1:0]          hit, free_oh;

    assign consume = ready && rd_n_q;

    always_comb begin
        state_d    = state_q;
        on_d       = on_q;
        code_d     = code_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        drop_d     = 1'b0;
        is_make    = 1'b0;
        is_break   = 1'b0;
        held       = 1'b0;
        hit        = '0;
        free_oh    = '0;
        free_found = 1'b0;
        freq_d     = '0;

        for (int i = 0; i < VOICES; i++) begin
            if (on_q[i] && code_q[i] == byte_q) begin
                hit[i] = 1'b1;
                held   = 1'b1;
            end
            if (!on_q[i] && !free_found) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
        end

        // Overflow discards whatever byte is in flight, including one awaiting decode.
        if (overflow) begin
            state_d = IDLE;
        end else if (byte_vld_q) begin
            case (state_q)
                IDLE: begin
                    if (byte_q == 8'hF0)      state_d = BRK;
                    else if (byte_q == 8'hE0) state_d = EXT;
                    else                      is_make = 1'b1;
                end
                BRK: begin
                    if (byte_q == 8'hF0)      state_d = BRK;
                    else if (byte_q == 8'hE0) state_d = EXT_BRK;
                    else begin
                        is_break = 1'b1;
                        state_d  = IDLE;
                    end
                end
                EXT:     state_d = (byte_q == 8'hF0) ? EXT_BRK : IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (is_make) begin
            if (note_freq(byte_q) == '0) begin
                last_d = byte_q;
            end else if (!held) begin
                if (free_found) begin
                    on_d   = on_q | free_oh;
                    cnt_d  = cnt_q + CNT_W'(1);
                    last_d = byte_q;
                    for (int i = 0; i < VOICES; i++) begin
                        if (free_oh[i]) code_d[i] = byte_q;
                    end
                end else begin
                    drop_d = 1'b1;
                end
            end
        end

        if (is_break) on_d = on_q & ~hit;
        if (panic)    on_d = '0;

        for (int i = 0; i < VOICES; i++) begin
            freq_d[i*FREQ_W +: FREQ_W] = on_d[i] ? note_freq(code_d[i]) : '0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            rd_n_q     <= 1'b1;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            on_q       <= '0;
            code_q     <= '{default: '0};
            freq_q     <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_n_q     <= !consume;
            byte_vld_q <= consume && !overflow;
            if (consume) byte_q <= k_data;
            on_q       <= on_d;
            code_q     <= code_d;
            freq_q     <= freq_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            if (overflow) err_q <= 1'b1;
        end
    end

    assign nextdata_n = rd_n_q;
    assign voice_on   = on_q;
    assign voice_freq = freq_q;
    assign last_code  = last_q;
    assign keycount   = cnt_q;
    assign drop       = drop_q;
    assign err        = err_q;

endmodule

// File: doc/ps2_note_voices.md
# ps2_note_voices

Polyphonic successor to the single-key PS/2 note decoder. The block consumes scan-code bytes from `ps2_keyboard`, decodes make, break (F0) and extended (E0) sequences, and tracks up to VOICES simultaneously held note keys. Each held key gets its own voice slot, and each slot drives a frequency word. It sits between `ps2_keyboard` and the multi-channel tone generators, and also feeds the key-press counter display.

## Interface
- VOICES, 4, number of voice slots (1–8)
- FREQ_W, 16, width of each frequency word
- CNT_W, 8, width of key-press counter
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- k_data  in  8  byte from ps2_keyboard
- ready  in  1  ps2_keyboard has an unread byte
- overflow  in  1  ps2_keyboard FIFO overflow
- panic  in  1  synchronous all-notes-off
- nextdata_n  out  1  active-low read strobe to ps2_keyboard
- voice_on  out  VOICES  slot i holds a key
- voice_freq  out  VOICES*FREQ_W  slot i frequency at bits [i*FREQ_W +: FREQ_W]; 0 when slot is idle
- last_code  out  8  most recent accepted make code
- keycount  out  CNT_W  accepted note-on count, wraps modulo 2^CNT_W
- drop  out  1  one-cycle pulse: note-on refused because all slots are full
- err  out  1  sticky; set by overflow, cleared only by reset

## Operation
- **Reset values:** nextdata_n=1; all other outputs 0; FSM in IDLE; all slot codes 0.
- **Byte consume:** a byte is consumed in a cycle where ready=1 and nextdata_n=1. In that cycle nextdata_n is driven 0 for exactly one cycle, then returns to 1. This gives at most one byte per 2 cycles.
- **FSM states:** IDLE, BRK, EXT, EXT_BRK.
  - IDLE: F0→BRK; E0→EXT; any other byte is a make code, stay IDLE.
  - BRK: F0→BRK; E0→EXT_BRK; any other byte is a break code, then →IDLE.
  - EXT: F0→EXT_BRK; any other byte is discarded, →IDLE.
  - EXT_BRK: any byte is discarded, →IDLE.
- **Note table** (code→freq): 1C→0106, 1B→0115, 23→0126, 2B→0137, 34→014A, 33→015D, 3B→0172, 42→0188, 4B→019F, 4C→01B8, 52→01D2, 5A→01EE.
  - Values are hex and zero-extended to FREQ_W.
  - Unlisted codes are unmapped.
- **Make, mapped, code already held in a slot:** typematic repeat; no state change, no count.
- **Make, mapped, not held:**
  - Allocate the lowest-index idle slot, store the code, set voice_on.
  - keycount+1; last_code updated.
  - If no slot is idle: pulse drop; no slot, count or last_code change.
- **Make, unmapped:** last_code updated only.
- **Break:** clear the slot holding that code. A break for a code that is not held is ignored.
- **panic=1:** clears every voice_on in that cycle; FSM and counters are unaffected. If panic coincides with an allocation, panic wins and all slots end up idle.
- **overflow=1:** FSM is forced to IDLE and err is set. Voices are kept. If a byte is consumed in the same cycle, that byte is discarded.
- **voice_freq:** registered; equals table(slot code) when voice_on[i]=1, else 0.

## Timing
- Byte consumed at edge T → voice_on, voice_freq, keycount, last_code and drop are all valid after edge T+1, i.e. one cycle of latency.
- drop is high for exactly one cycle.
- nextdata_n is low only in the cycle after a consume edge. A ready that stays high keeps producing back-to-back reads every 2 cycles.
- clrn asserted mid-sequence (e.g. after F0) → FSM returns to IDLE immediately. The next byte is treated as a make.

## Test plan
- Reset, then bytes 1C, F0, 1C → after byte 1: voice_on=0001, voice_freq[0]=0106, keycount=1. After the break: voice_on=0000, voice_freq[0]=0.
- Makes 1C, 1B, 23, 2B, then 34 → slots 0–3 filled with 0106/0115/0126/0137. The fifth make pulses drop for 1 cycle; keycount=4.
- Makes 1C, 1C, 1C (typematic) → one slot used, keycount=1. Then F0 1B (not held) → no change.
- Bytes E0, 1C then E0, F0, 1C → no voice allocated, FSM back in IDLE. Then 1C → slot 0 on.
- Hold 3 keys, assert panic one cycle → voice_on=0000, keycount unchanged. Separately, assert overflow between F0 and 1C → err=1; the following 1C is treated as a make.
- Hold ready high with 256 distinct make/break pairs of 5A → nextdata_n pulses every 2 cycles; keycount wraps to 0.
